// File: rtl/physics_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler and the per-player physics units.
// The scheduler drives step_req and samples step_done and the unit positions.
interface physics_frame_scheduler_if #(
    parameter int unsigned NUM_PLAYERS = 2
);
    logic [NUM_PLAYERS-1:0]    step_req;
    logic [NUM_PLAYERS-1:0]    step_done;
    logic [32*NUM_PLAYERS-1:0] position_in;

    modport master (
        output step_req,
        input  step_done,
        input  position_in
    );

    modport slave (
        input  step_req,
        output step_done,
        output position_in
    );
endinterface

// File: rtl/physics_frame_scheduler.sv
// Per-frame sequencer for the player physics units.
// Each frame tick steps every unit once over a req/done handshake.
// Each result is captured into a shadow bank. All positions are then published in one edge.
// Optional feature macro: PHYS_SCHED_ROTATE_EN (rotate the first-served player every frame).
module physics_frame_scheduler #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic                        clock_i,
    input  logic                        reset_ni,
    input  logic                        frame_tick_i,
    input  logic                        freeze_all_i,
    physics_frame_scheduler_if.master   units,
    output logic [32*NUM_PLAYERS-1:0]   position_out_o,
    output logic                        frame_busy_o,
    output logic                        frame_done_o,
    output logic [7:0]                  overrun_count_o,
    output logic [NUM_PLAYERS-1:0]      timeout_flags_o
);

    localparam int unsigned IW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_COMMIT
    } state_t;

    state_t                    state_q;
    logic [IW-1:0]             idx_q;
    logic [IW-1:0]             served_q;
    logic [CW-1:0]             cnt_q;
    logic [15:0]               frame_cnt_q;
    logic [NUM_PLAYERS-1:0]    step_req_q;
    logic [31:0]               shadow_q [NUM_PLAYERS];
    logic [32*NUM_PLAYERS-1:0] position_out_q;
    logic                      frame_done_q;
    logic [7:0]                overrun_q;
    logic [NUM_PLAYERS-1:0]    timeout_flags_q;

    logic [IW-1:0]             start_d;
    logic [IW-1:0]             idx_next_d;

    // First player served in a frame, and the wrap-around successor of the current player
    always_comb begin
`ifdef PHYS_SCHED_ROTATE_EN
        start_d = IW'(32'(frame_cnt_q) % 32'(NUM_PLAYERS));
`else
        start_d = '0;
`endif
        idx_next_d = (idx_q == IW'(NUM_PLAYERS - 1)) ? '0 : idx_q + 1'b1;
    end

    // Frame sequencing FSM.
    // The last player also takes its gap cycle, so every player costs exactly three cycles.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            served_q        <= '0;
            cnt_q           <= '0;
            frame_cnt_q     <= '0;
            step_req_q      <= '0;
            position_out_q  <= '0;
            frame_done_q    <= 1'b0;
            timeout_flags_q <= '0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_tick_i) begin
                        if (freeze_all_i) begin
                            state_q <= S_COMMIT;
                        end else begin
                            idx_q    <= start_d;
                            served_q <= '0;
                            state_q  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    step_req_q        <= '0;
                    step_req_q[idx_q] <= 1'b1;
                    cnt_q             <= '0;
                    state_q           <= S_WAIT;
                end
                S_WAIT: begin
                    if (units.step_done[idx_q]) begin
                        shadow_q[idx_q] <= units.position_in[32*int'(idx_q) +: 32];
                        step_req_q      <= '0;
                        state_q         <= S_GAP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        step_req_q             <= '0;
                        timeout_flags_q[idx_q] <= 1'b1;
                        state_q                <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (served_q == IW'(NUM_PLAYERS - 1)) begin
                        state_q <= S_COMMIT;
                    end else begin
                        idx_q    <= idx_next_d;
                        served_q <= served_q + 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_COMMIT: begin
                    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                        position_out_q[32*i +: 32] <= shadow_q[i];
                    end
                    frame_done_q <= 1'b1;
                    frame_cnt_q  <= frame_cnt_q + 16'd1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    step_req_q <= '0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // Saturating count of frame ticks that arrive while a frame is still in flight
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            overrun_q <= '0;
        end else if (frame_tick_i && (state_q != S_IDLE) && (overrun_q != 8'hFF)) begin
            overrun_q <= overrun_q + 8'd1;
        end
    end

    assign units.step_req  = step_req_q;
    assign position_out_o  = position_out_q;
    assign frame_busy_o    = (state_q != S_IDLE);
    assign frame_done_o    = frame_done_q;
    assign overrun_count_o = overrun_q;
    assign timeout_flags_o = timeout_flags_q;

endmodule

// File: tb/tb_physics_frame_scheduler.sv
// Directed bench for physics_frame_scheduler (NUM_PLAYERS=2, TIMEOUT=16).
module tb_physics_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_tick;
    logic        freeze_all;
    logic [1:0]  resp_en;
    logic [31:0] pos0, pos1;
    logic [63:0] position_out;
    logic        frame_busy;
    logic        frame_done;
    logic [7:0]  overrun_count;
    logic [1:0]  timeout_flags;
    logic [63:0] exp_pos;

    int n_checks = 0;
    int n_errors = 0;

    physics_frame_scheduler_if #(.NUM_PLAYERS(2)) uif ();

    // Units answer done in the same cycle they see their request
    assign uif.step_done   = uif.step_req & resp_en;
    assign uif.position_in = {pos1, pos0};

    physics_frame_scheduler #(
        .NUM_PLAYERS(2),
        .TIMEOUT    (16)
    ) dut (
        .clock_i        (clk),
        .reset_ni       (reset_n),
        .frame_tick_i   (frame_tick),
        .freeze_all_i   (freeze_all),
        .units          (uif.master),
        .position_out_o (position_out),
        .frame_busy_o   (frame_busy),
        .frame_done_o   (frame_done),
        .overrun_count_o(overrun_count),
        .timeout_flags_o(timeout_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tick is sampled at the edge inside this task (edge T); returns at T+1ns
    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int waited;
        waited = 0;
        while (frame_busy && waited < 200) begin
            step();
            waited++;
        end
        check(tag, {63'd0, frame_busy}, 64'd0);
        step();
    endtask

    initial begin
        int pulses;
        logic [1:0] exp_req;

        reset_n    = 1'b0;
        frame_tick = 1'b0;
        freeze_all = 1'b0;
        resp_en    = 2'b11;
        pos0       = 32'h0064_0032;
        pos1       = 32'h012C_0032;
        #12;
        check("rst_req",   {62'd0, uif.step_req}, 64'd0);
        check("rst_pos",   position_out, 64'd0);
        check("rst_busy",  {63'd0, frame_busy}, 64'd0);
        check("rst_done",  {63'd0, frame_done}, 64'd0);
        check("rst_ovr",   {56'd0, overrun_count}, 64'd0);
        check("rst_flags", {62'd0, timeout_flags}, 64'd0);
        reset_n = 1'b1;
        step();

        // Nominal frame: req[0] at T+1, req[1] at T+4, frame_done at T+7
        tick();
        step(); check("nom_req_t1", {62'd0, uif.step_req}, 64'd1);
        step(); check("nom_req_t2", {62'd0, uif.step_req}, 64'd0);
        check("nom_busy_t2", {63'd0, frame_busy}, 64'd1);
        step();
        step(); check("nom_req_t4", {62'd0, uif.step_req}, 64'd2);
        step();
        step(); check("nom_done_t6", {63'd0, frame_done}, 64'd0);
        check("nom_pos_t6", position_out, 64'd0);
        step(); check("nom_done_t7", {63'd0, frame_done}, 64'd1);
        exp_pos = 64'h012C_0032_0064_0032;
        check("nom_pos_t7", position_out, exp_pos);
        step(); check("nom_done_t8", {63'd0, frame_done}, 64'd0);
        check("nom_busy_t8", {63'd0, frame_busy}, 64'd0);

        // Unit 1 never answers: req[1] high T+4..T+19, dropped at T+20, commit at T+22
        resp_en = 2'b01;
        pos0    = 32'h00AA_00BB;
        pos1    = 32'h1111_2222;
        tick();
        repeat (19) step();
        check("to_req_t19", {62'd0, uif.step_req}, 64'd2);
        check("to_flags_t19", {62'd0, timeout_flags}, 64'd0);
        step();
        check("to_req_t20", {62'd0, uif.step_req}, 64'd0);
        check("to_flags_t20", {62'd0, timeout_flags}, 64'd2);
        step();
        check("to_done_t21", {63'd0, frame_done}, 64'd0);
        step();
        check("to_done_t22", {63'd0, frame_done}, 64'd1);
        exp_pos = 64'h012C_0032_00AA_00BB;
        check("to_pos_t22", position_out, exp_pos);
        step();

        // Second tick two cycles into a frame is dropped
        resp_en = 2'b11;
        pos0    = 32'h0001_0002;
        pos1    = 32'h0003_0004;
        tick();
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        pulses = 0;
        for (int k = 3; k <= 14; k++) begin
            step();
            if (frame_done) pulses++;
        end
        check("ovr_one_frame_done", 64'(pulses), 64'd1);
        check("ovr_count_1", {56'd0, overrun_count}, 64'd1);
        exp_pos = 64'h0003_0004_0001_0002;
        check("ovr_pos", position_out, exp_pos);

        // Stalled units with a tick every cycle: overrun saturates
        resp_en    = 2'b00;
        frame_tick = 1'b1;
        repeat (300) step();
        frame_tick = 1'b0;
        check("ovr_sat", {56'd0, overrun_count}, 64'd255);
        wait_idle("stall_idle");
        check("stall_flags", {62'd0, timeout_flags}, 64'd3);
        check("stall_pos", position_out, exp_pos);
        check("ovr_sat_hold", {56'd0, overrun_count}, 64'd255);

        // Freeze: no steps, frame_done one cycle after tick, positions republished unchanged
        resp_en    = 2'b11;
        pos0       = 32'hDEAD_0001;
        pos1       = 32'hDEAD_0002;
        freeze_all = 1'b1;
        tick();
        step();
        check("frz_req", {62'd0, uif.step_req}, 64'd0);
        check("frz_done", {63'd0, frame_done}, 64'd1);
        check("frz_pos", position_out, exp_pos);
        step();
        check("frz_done_off", {63'd0, frame_done}, 64'd0);
        check("frz_busy", {63'd0, frame_busy}, 64'd0);
        freeze_all = 1'b0;

        // Reset while req[1] is high clears everything immediately
        tick();
        repeat (4) step();
        check("mid_req_pre", {62'd0, uif.step_req}, 64'd2);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_req",   {62'd0, uif.step_req}, 64'd0);
        check("mid_rst_pos",   position_out, 64'd0);
        check("mid_rst_busy",  {63'd0, frame_busy}, 64'd0);
        check("mid_rst_ovr",   {56'd0, overrun_count}, 64'd0);
        check("mid_rst_flags", {62'd0, timeout_flags}, 64'd0);
        #3 reset_n = 1'b1;
        step();

        // Three frames after reset: first-served player 0,1,0 with rotation, else always 0
        pos0 = 32'h0000_0005;
        pos1 = 32'h0000_0006;
        tick();
        step();
        check("rot_f0_first", {62'd0, uif.step_req}, 64'd1);
        wait_idle("rot_f0_idle");
        check("rot_f0_pos", position_out, 64'h0000_0006_0000_0005);
`ifdef PHYS_SCHED_ROTATE_EN
        exp_req = 2'b10;
`else
        exp_req = 2'b01;
`endif
        tick();
        step();
        check("rot_f1_first", {62'd0, uif.step_req}, {62'd0, exp_req});
        wait_idle("rot_f1_idle");
        tick();
        step();
        check("rot_f2_first", {62'd0, uif.step_req}, 64'd1);
        wait_idle("rot_f2_idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
